// File: rtl/spart_pkg.sv
// Shared definitions for the SPART transmit path: register addresses and
// the transmit arbiter state encoding.
package spart_pkg;

  localparam logic [1:0] ADDR_TX     = 2'd0;
  localparam logic [1:0] ADDR_DIV_LO = 2'd2;
  localparam logic [1:0] ADDR_DIV_HI = 2'd3;

  typedef enum logic [2:0] {
    CFG_LO   = 3'd0,
    CFG_HI   = 3'd1,
    IDLE     = 3'd2,
    WRITE    = 3'd3,
    WAIT_TBR = 3'd4
  } state_t;

endpackage

// File: rtl/spart_rr_arb.sv
// Two-requester arbiter. Default build is round-robin; defining
// SPART_TX_FIXED_PRIO_EN makes requester 0 always win and drops the pointer.
module spart_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

`ifdef SPART_TX_FIXED_PRIO_EN
  logic w_unused;
  assign w_unused = clk ^ rst ^ advance;

  always_comb begin
    grant = 2'b00;
    if (req[0])      grant = 2'b01;
    else if (req[1]) grant = 2'b10;
  end
`else
  // r_prio names the requester that wins a tie; it moves away from each winner.
  logic r_prio;

  always_ff @(posedge clk) begin
    if (rst)                       r_prio <= 1'b0;
    else if (advance && |grant)    r_prio <= grant[0];
  end

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = r_prio ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end
`endif

endmodule

// File: rtl/spart_tx_arbiter.sv
// Shares one SPART transmitter between two byte sources: writes the baud
// divisor after reset, then forwards granted bytes (see spart_rr_arb).
module spart_tx_arbiter
  import spart_pkg::*;
#(
  parameter logic [15:0] DIVISOR = 16'd325
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [7:0]  data0,
  input  logic [7:0]  data1,
  output logic        gnt0,
  output logic        gnt1,
  input  logic        tbr,
  output logic        iocs,
  output logic        iorw,
  output logic [1:0]  ioaddr,
  output logic [7:0]  databus,
  output logic        cfg_done,
  output logic [15:0] tx_count,
  output logic [2:0]  o_dbg_state
);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_hold;
  logic        r_win;
  logic        r_cfg_done;
  logic [15:0] r_tx_count;
  wire  [15:0] w_tx_count_nxt;

  logic [1:0]  w_req, w_grant;
  logic        w_advance;
  logic        w_iocs, w_g0, w_g1;
  logic [1:0]  w_addr;
  logic [7:0]  w_bus;

  assign w_req     = {req1, req0};
  assign w_advance = (r_state == IDLE) && tbr && (|w_req);

  spart_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_req),
    .advance (w_advance),
    .grant   (w_grant)
  );

  assign w_tx_count_nxt = ((r_state == WRITE) && (r_tx_count != 16'hFFFF))
                        ? r_tx_count + 16'd1 : r_tx_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= CFG_LO;
      r_hold     <= 8'h00;
      r_win      <= 1'b0;
      r_cfg_done <= 1'b0;
      r_tx_count <= 16'h0000;
    end else begin
      r_state    <= w_state_nxt;
      r_tx_count <= w_tx_count_nxt;
      if (w_advance) begin
        r_hold <= w_grant[1] ? data1 : data0;
        r_win  <= w_grant[1];
      end
      if (r_state == CFG_HI) r_cfg_done <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_iocs      = 1'b0;
    w_addr      = ADDR_TX;
    w_bus       = 8'h00;
    w_g0        = 1'b0;
    w_g1        = 1'b0;
    case (r_state)
      CFG_LO: begin
        w_iocs      = 1'b1;
        w_addr      = ADDR_DIV_LO;
        w_bus       = DIVISOR[7:0];
        w_state_nxt = CFG_HI;
      end
      CFG_HI: begin
        w_iocs      = 1'b1;
        w_addr      = ADDR_DIV_HI;
        w_bus       = DIVISOR[15:8];
        w_state_nxt = IDLE;
      end
      IDLE: begin
        if (w_advance) w_state_nxt = WRITE;
      end
      WRITE: begin
        w_iocs      = 1'b1;
        w_addr      = ADDR_TX;
        w_bus       = r_hold;
        w_g0        = ~r_win;
        w_g1        = r_win;
        w_state_nxt = WAIT_TBR;
      end
      // tbr drops a cycle after the write, so it is only sampled from here on.
      WAIT_TBR: begin
        if (tbr) w_state_nxt = IDLE;
      end
      default: w_state_nxt = CFG_LO;
    endcase
  end

  // Reset masks the bus immediately so a write in flight is abandoned.
  assign iocs        = w_iocs & ~rst;
  assign iorw        = 1'b0;
  assign ioaddr      = iocs ? w_addr : 2'd0;
  assign databus     = iocs ? w_bus : 8'h00;
  assign gnt0        = w_g0 & ~rst;
  assign gnt1        = w_g1 & ~rst;
  assign cfg_done    = r_cfg_done;
  assign tx_count    = r_tx_count;
  assign o_dbg_state = r_state;

endmodule

// File: doc/spart_tx_arbiter.md
SPART_TX_ARBITER -- requirements
Module: spart_tx_arbiter

Interface
REQ-001 The block SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-002 The block SHALL have parameter DIVISOR, default 16'd325, meaning the baud divisor written to the SPART after reset.
REQ-003 Port clk: input, 1 bit, system clock.
REQ-004 Port rst: input, 1 bit, synchronous active-high reset.
REQ-005 Port req0 / req1: input, 1 bit each, requester n holds a byte to send; held until its gnt.
REQ-006 Port data0 / data1: input, 8 bits each, byte from requester n, stable while reqn=1.
REQ-007 Port gnt0 / gnt1: output, 1 bit each, one-cycle pulse; the byte was written to the transmitter this cycle.
REQ-008 Port tbr: input, 1 bit, transmit buffer ready from the transmitter.
REQ-009 Port iocs: output, 1 bit, SPART chip select.
REQ-010 Port iorw: output, 1 bit, 0 = write; always 0 when iocs=1.
REQ-011 Port ioaddr: output, 2 bits; 0 = TX data, 2 = divisor low, 3 = divisor high.
REQ-012 Port databus: output, 8 bits, write data; drive-only, 8'h00 when iocs=0.
REQ-013 Port cfg_done: output, 1 bit, high once both divisor bytes are written.
REQ-014 Port tx_count: output, 16 bits, bytes granted since reset; saturates at 16'hFFFF.

Function
REQ-015 The FSM SHALL have the states CFG_LO, CFG_HI, IDLE, WRITE and WAIT_TBR.
REQ-016 CFG_LO SHALL drive iocs=1, ioaddr=2 and databus=DIVISOR[7:0] for exactly one cycle, then go to CFG_HI.
REQ-017 CFG_HI SHALL drive iocs=1, ioaddr=3 and databus=DIVISOR[15:8] for one cycle, then go to IDLE and set cfg_done=1 from the next cycle.
REQ-018 In IDLE with tbr=1 and any request, the block SHALL select the winner, latch its data into an 8-bit hold register and go to WRITE.
REQ-019 In IDLE, the block SHALL wait while tbr=0 or there are no requests.
REQ-020 WRITE SHALL last one cycle: iocs=1, ioaddr=0, databus=hold register, gnt of the winner=1; then go to WAIT_TBR.
REQ-021 WAIT_TBR SHALL stay until tbr=1, then return to IDLE.
REQ-022 The WAIT_TBR exit SHALL require at least one cycle in WAIT_TBR, covering the one-cycle tbr fall delay.
REQ-023 Latency from a request sampled in IDLE with tbr=1 to iocs/gnt SHALL be exactly 1 cycle.
REQ-024 With the default build, arbitration SHALL be round-robin: a 1-bit last-grant pointer updates on every WRITE, and on simultaneous requests the requester not last granted wins.
REQ-025 A single request SHALL win regardless of the pointer.
REQ-026 A requester that drops req before grant SHALL be treated as withdrawn, with no grant issued.
REQ-027 A request arriving during WRITE or WAIT_TBR SHALL be considered only at the next IDLE.
REQ-028 tx_count SHALL increment on each WRITE cycle and hold at 16'hFFFF.
REQ-029 At most one gnt SHALL be high in any cycle.

Reset
REQ-030 On rst, the state SHALL become CFG_LO, and iocs, gnt0, gnt1, cfg_done, tx_count, the pointer (favouring requester 0) and the hold register SHALL clear.
REQ-031 A mid-operation reset SHALL abort any write, issue no gnt, and repeat divisor configuration.
REQ-032 The first cycle after rst deasserts SHALL be the CFG_LO write.

Configuration
REQ-033 When SPART_TX_FIXED_PRIO_EN is defined, req0 SHALL always beat req1 and the pointer SHALL be removed.
REQ-034 When SPART_TX_FIXED_PRIO_EN is undefined, the round-robin of REQ-024 SHALL apply.

Structure
REQ-035 Shared package spart_pkg SHALL hold the ioaddr constants (TX data 0, divisor low 2, divisor high 3) and the FSM state enum.
REQ-036 Arbitration SHALL live in sub-module spart_rr_arb (req[1:0], advance -> grant[1:0]), containing the macro-selected logic.

Verification
REQ-037 Reset release, DIVISOR=16'h0145: cycle 1 iocs=1, ioaddr=2, databus=8'h45; cycle 2 ioaddr=3, databus=8'h01; cycle 3 cfg_done=1.
REQ-038 req0 with data0=8'hA5, tbr=1 in IDLE: next cycle iocs=1, ioaddr=0, databus=8'hA5, gnt0=1; tx_count=1.
REQ-039 Both requesters held continuously, tbr returning 3 cycles after each write: grants alternate 0,1,0,1; with SPART_TX_FIXED_PRIO_EN, all grants go to 0.
REQ-040 tbr held 0 for 50 cycles in WAIT_TBR with req1 high: no iocs and no gnt until tbr=1, then WRITE with gnt1.
REQ-041 rst asserted during WRITE: gnt suppressed, tx_count=0, then the CFG_LO/CFG_HI sequence repeats.
REQ-042 tx_count preloaded via force to 16'hFFFE, then 3 grants: reads 16'hFFFF and holds.
